// File: rtl/fpu_mult_arb.sv
// Two-requester round-robin front end for a shared pipelined mantissa
// multiplier, tracking operands/tags alongside the product pipeline.
module fpu_mult_arb #(
  parameter int LAT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_opa,
  input  logic [31:0] req0_opb,
  input  logic [4:0]  req0_tag,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_opa,
  input  logic [31:0] req1_opb,
  input  logic [4:0]  req1_tag,
  output logic        req1_ready,
  output logic        mul_en,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  input  logic [47:0] mul_result,
  output logic        res_valid,
  output logic [31:0] res_opa,
  output logic [31:0] res_opb,
  output logic [47:0] res_product,
  output logic [4:0]  res_tag,
  output logic        res_src,
  input  logic        res_ready,
  output logic        busy
);

  logic [LAT-1:0] r_vld;
  logic [LAT-1:0] r_src;
  logic [31:0]    r_opa [LAT];
  logic [31:0]    r_opb [LAT];
  logic [4:0]     r_tag [LAT];
  logic           r_ptr;

  logic        w_stall;
  logic        w_g0;
  logic        w_g1;
  logic        w_gnt;
  logic [31:0] w_gopa;
  logic [31:0] w_gopb;
  logic [4:0]  w_gtag;

  assign w_stall = r_vld[LAT-1] & ~res_ready;
  assign mul_en  = ~w_stall;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (!reset && !w_stall) begin
      if (req0_valid && req1_valid) begin
        w_g0 = ~r_ptr;
        w_g1 = r_ptr;
      end else begin
        w_g0 = req0_valid;
        w_g1 = req1_valid;
      end
    end
  end

  assign w_gnt  = w_g0 | w_g1;
  assign w_gopa = w_g1 ? req1_opa : req0_opa;
  assign w_gopb = w_g1 ? req1_opb : req0_opb;
  assign w_gtag = w_g1 ? req1_tag : req0_tag;

  assign mul_a = w_gnt ? {|w_gopa[30:23], w_gopa[22:0]} : 24'd0;
  assign mul_b = w_gnt ? {|w_gopb[30:23], w_gopb[22:0]} : 24'd0;

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld <= '0;
      r_ptr <= 1'b0;
    end else if (!w_stall) begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_vld[0] <= w_gnt;
      if (w_gnt) begin
        r_ptr <= w_g0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!w_stall) begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_opa[i] <= r_opa[i-1];
        r_opb[i] <= r_opb[i-1];
        r_tag[i] <= r_tag[i-1];
        r_src[i] <= r_src[i-1];
      end
      r_opa[0] <= w_gopa;
      r_opb[0] <= w_gopb;
      r_tag[0] <= w_gtag;
      r_src[0] <= w_g1;
    end
  end

  assign res_valid   = r_vld[LAT-1];
  assign res_opa     = r_opa[LAT-1];
  assign res_opb     = r_opb[LAT-1];
  assign res_tag     = r_tag[LAT-1];
  assign res_src     = r_src[LAT-1];
  assign res_product = mul_result;
  assign busy        = |r_vld;

endmodule

// File: tb/tb_fpu_mult_arb.sv
// Bench for fpu_mult_arb: queue-based reference model plus a behavioural
// LAT-stage multiplier driven by the DUT's mul_en/mul_a/mul_b.
module tb_fpu_mult_arb;
  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_opa = '0;
  logic [31:0] req0_opb = '0;
  logic [4:0]  req0_tag = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_opa = '0;
  logic [31:0] req1_opb = '0;
  logic [4:0]  req1_tag = '0;
  logic        req1_ready;
  logic        mul_en;
  logic [23:0] mul_a;
  logic [23:0] mul_b;
  logic [47:0] mul_result;
  logic        res_valid;
  logic [31:0] res_opa;
  logic [31:0] res_opb;
  logic [47:0] res_product;
  logic [4:0]  res_tag;
  logic        res_src;
  logic        res_ready = 1'b1;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_mult_arb #(.LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opa(req1_opa), .req1_opb(req1_opb),
    .req1_tag(req1_tag), .req1_ready(req1_ready),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .res_valid(res_valid), .res_opa(res_opa), .res_opb(res_opb),
    .res_product(res_product), .res_tag(res_tag), .res_src(res_src),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  // Shared multiplier environment: advances only when mul_en is high.
  logic [47:0] mp [LAT];
  initial foreach (mp[i]) mp[i] = '0;
  always @(posedge clock) begin
    if (mul_en) begin
      for (int i = LAT - 1; i > 0; i--) mp[i] <= mp[i-1];
      mp[0] <= {24'd0, mul_a} * {24'd0, mul_b};
    end
  end
  assign mul_result = mp[LAT-1];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        src;
    int          age;
  } ent_t;

  ent_t        mq[$];
  logic        m_ptr = 1'b0;
  logic        pend = 1'b0;
  logic        e_rst, e_resv, e_stall, e_busy, e_g0, e_g1;
  logic [23:0] e_ma, e_mb;
  ent_t        e_new;

  function automatic logic [23:0] mant(input logic [31:0] x);
    return {(x[30:23] != 8'd0), x[22:0]};
  endfunction

  function automatic logic [47:0] prod(input logic [31:0] a, b);
    return {24'd0, mant(a)} * {24'd0, mant(b)};
  endfunction

  // Entry is at the output once it has seen LAT-1 advancing edges.
  task automatic model_eval();
    e_rst   = reset;
    e_resv  = (mq.size() > 0) && (mq[0].age == LAT - 1);
    e_stall = e_resv && !res_ready;
    e_busy  = (mq.size() > 0);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!e_rst && !e_stall) begin
      if (req0_valid && req1_valid) begin
        if (m_ptr) e_g1 = 1'b1;
        else e_g0 = 1'b1;
      end else begin
        e_g0 = req0_valid;
        e_g1 = req1_valid;
      end
    end
    e_new.a   = e_g1 ? req1_opa : req0_opa;
    e_new.b   = e_g1 ? req1_opb : req0_opb;
    e_new.tag = e_g1 ? req1_tag : req0_tag;
    e_new.src = e_g1;
    e_new.age = 0;
    e_ma = (e_g0 || e_g1) ? mant(e_new.a) : 24'd0;
    e_mb = (e_g0 || e_g1) ? mant(e_new.b) : 24'd0;
  endtask

  task automatic model_adv();
    if (e_rst) begin
      mq.delete();
      m_ptr = 1'b0;
    end else if (!e_stall) begin
      if (e_resv) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (e_g0 || e_g1) begin
        mq.push_back(e_new);
        m_ptr = e_g0;
      end
    end
  endtask

  task automatic drive(input logic rst,
                       input logic v0, input logic [31:0] a0, b0,
                       input logic [4:0] t0,
                       input logic v1, input logic [31:0] a1, b1,
                       input logic [4:0] t1, input logic rr);
    if (pend) model_adv();
    @(negedge clock);
    reset = rst;
    req0_valid = v0; req0_opa = a0; req0_opb = b0; req0_tag = t0;
    req1_valid = v1; req1_opa = a1; req1_opb = b1; req1_tag = t1;
    res_ready = rr;
    #1;
    model_eval();
    pend = 1'b1;
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic both(input logic [4:0] t, input logic rr);
    drive(1'b0, 1'b1, 32'h3F80_0000 + 32'(t), 32'h4000_0000, t,
          1'b1, 32'h4040_0000 + 32'(t), 32'h3F00_0000, t + 5'd16, rr);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h1, 32'h1, 5'd1, 1'b1, 32'h2, 32'h2, 5'd2, 1'b1);
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    idle(1'b1);
    n_cmp++;
    if ({res_valid, busy, req0_ready, req1_ready, mul_en} !== 5'b00001) begin
      n_bad++;
      $display("FAIL post_reset: got v%b b%b r%b%b en%b want v0 b0 r00 en1",
               res_valid, busy, req0_ready, req1_ready, mul_en);
    end
  endtask

  task automatic test_single();
    drive(1'b0, 1'b1, 32'h4000_0000, 32'h3FC0_0000, 5'd7,
          1'b0, '0, '0, '0, 1'b1);
    n_cmp++;
    if (req0_ready !== 1'b1 || mul_a !== 24'h80_0000 || mul_b !== 24'hC0_0000) begin
      n_bad++;
      $display("FAIL single_issue: rdy %b a %h b %h want 1 800000 c00000",
               req0_ready, mul_a, mul_b);
    end
    for (int i = 1; i <= LAT; i++) begin
      idle(1'b1);
      n_cmp++;
      if (res_valid !== (i == LAT)) begin
        n_bad++;
        $display("FAIL single_lat: cyc %0d res_valid %b", i, res_valid);
      end
    end
    n_cmp++;
    if (res_tag !== 5'd7 || res_src !== 1'b0 ||
        res_product !== 48'h6000_0000_0000) begin
      n_bad++;
      $display("FAIL single_res: tag %0d src %b prod %h want 7 0 600000000000",
               res_tag, res_src, res_product);
    end
    drive(1'b0, 1'b1, 32'h0000_0001, 32'h3F80_0000, 5'd9,
          1'b0, '0, '0, '0, 1'b1);
    n_cmp++;
    if (mul_a !== 24'h00_0001 || mul_b !== 24'h80_0000) begin
      n_bad++;
      $display("FAIL denorm: a %h b %h want 000001 800000", mul_a, mul_b);
    end
    for (int i = 0; i < LAT; i++) idle(1'b1);
  endtask

  task automatic test_alternate();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      both(5'(i), 1'b1);
      n_cmp++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_bad++;
        $display("FAIL alt_grant: cyc %0d got %b%b", i, req0_ready, req1_ready);
      end
      if (i >= LAT) begin
        n_cmp++;
        if (res_valid !== 1'b1 || res_src !== 1'((i - LAT) % 2)) begin
          n_bad++;
          $display("FAIL alt_src: cyc %0d v %b src %b want 1 %0d",
                   i, res_valid, res_src, (i - LAT) % 2);
        end
      end
    end
    for (int i = 0; i < LAT; i++) idle(1'b1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < LAT + 1; i++) both(5'(i + 3), 1'b1);
    for (int i = 0; i < 4; i++) begin
      both(5'(i + 10), 1'b0);
      n_cmp++;
      if (mul_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
          res_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_ctl: cyc %0d en %b rdy %b%b v %b",
                 i, mul_en, req0_ready, req1_ready, res_valid);
      end
      n_cmp++;
      if (res_tag !== mq[0].tag || res_opa !== mq[0].a ||
          res_product !== prod(mq[0].a, mq[0].b)) begin
        n_bad++;
        $display("FAIL stall_hold: cyc %0d tag %0d want %0d prod %h",
                 i, res_tag, mq[0].tag, res_product);
      end
    end
    for (int i = 0; i < LAT + 1; i++) begin
      idle(1'b1);
      n_cmp++;
      if (res_valid !== e_resv || (e_resv && res_tag !== mq[0].tag)) begin
        n_bad++;
        $display("FAIL stall_drain: cyc %0d v %b tag %0d want v %b",
                 i, res_valid, res_tag, e_resv);
      end
    end
    n_cmp++;
    if (busy !== e_busy) begin
      n_bad++;
      $display("FAIL stall_busy: got %b want %b", busy, e_busy);
    end
  endtask

  task automatic test_reset_inflight();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 2; i++)
      drive(1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000, 5'(i),
            1'b0, '0, '0, '0, 1'b1);
    drive(1'b1, 1'b1, '0, '0, '0, 1'b1, '0, '0, '0, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL inflight_busy: got %b want 1", busy);
    end
    both(5'd5, 1'b1);
    n_cmp++;
    if ({busy, res_valid, req0_ready, req1_ready} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_flush: b %b v %b rdy %b%b want 0 0 10",
               busy, res_valid, req0_ready, req1_ready);
    end
    for (int i = 0; i < LAT; i++) idle(1'b1);
  endtask

  task automatic test_random();
    int n_acc;
    int n_res;
    n_acc = 0;
    n_res = 0;
    for (int i = 0; i < 400 + LAT + 2; i++) begin
      if (i < 400)
        drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom,
              5'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom,
              5'($urandom), 1'($urandom_range(0, 9) < 7));
      else
        idle(1'b1);
      if (e_g0 || e_g1) n_acc++;
      if (e_resv && !e_stall) n_res++;
      n_cmp++;
      if (req0_ready !== e_g0 || req1_ready !== e_g1 || mul_en !== !e_stall) begin
        n_bad++;
        $display("FAIL rnd_ctl: cyc %0d rdy %b%b en %b want %b%b %b",
                 i, req0_ready, req1_ready, mul_en, e_g0, e_g1, !e_stall);
      end
      n_cmp++;
      if (mul_a !== e_ma || mul_b !== e_mb) begin
        n_bad++;
        $display("FAIL rnd_mul: cyc %0d a %h b %h want %h %h",
                 i, mul_a, mul_b, e_ma, e_mb);
      end
      n_cmp++;
      if (res_valid !== e_resv || busy !== e_busy) begin
        n_bad++;
        $display("FAIL rnd_vld: cyc %0d v %b busy %b want %b %b",
                 i, res_valid, busy, e_resv, e_busy);
      end
      if (e_resv) begin
        n_cmp++;
        if (res_tag !== mq[0].tag || res_src !== mq[0].src ||
            res_opa !== mq[0].a || res_opb !== mq[0].b ||
            res_product !== prod(mq[0].a, mq[0].b)) begin
          n_bad++;
          $display("FAIL rnd_res: cyc %0d tag %0d src %b prod %h want %0d %b %h",
                   i, res_tag, res_src, res_product, mq[0].tag, mq[0].src,
                   prod(mq[0].a, mq[0].b));
        end
      end
    end
    n_cmp++;
    if (n_res != n_acc || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rnd_count: results %0d accepts %0d busy %b",
               n_res, n_acc, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
